// File: rtl/regbank_write_arbiter_pkg.sv
// Shared encodings and default widths for the register-bank write arbiter.
// Imported by the picker and the top level.
package regbank_write_arbiter_pkg;

  localparam int RB_AW   = 3;
  localparam int RB_W    = 32;
  localparam int RB_NREQ = 4;
  localparam int RB_IDW  = 3;

  typedef enum logic {
    RB_ST_IDLE   = 1'b0,
    RB_ST_LOCKED = 1'b1
  } rb_state_e;

  // Round-robin successor of a granted index, wrapping nreq-1 back to 0.
  function automatic logic [RB_IDW-1:0] rb_next_ptr(input logic [RB_IDW-1:0] g,
                                                    input int nreq);
    logic [RB_IDW-1:0] nxt;
    nxt = '0;
    if (int'(g) != nreq - 1) begin
      nxt = g + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo NREQ.
// Produces a one-hot grant, its index and an any-request flag.
module rr_pick
  import regbank_write_arbiter_pkg::*;
#(
  parameter int NREQ = RB_NREQ
) (
  input  logic [NREQ-1:0]   req,
  input  logic [RB_IDW-1:0] ptr,
  output logic [NREQ-1:0]   gnt,
  output logic [RB_IDW-1:0] idx,
  output logic              any
);

  logic [NREQ-1:0] req_rot;
  int unsigned     j;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    any     = 1'b0;
    req_rot = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j       = (int'(ptr) + k) % NREQ;
      req_rot = req >> j;
      if (!any && req_rot[0]) begin
        any = 1'b1;
        gnt = NREQ'(1) << j;
        idx = RB_IDW'(j);
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin write arbiter with per-requester bus lock in front of a 2**AW x W
// register bank; one combinational read port.
module regbank_write_arbiter
  import regbank_write_arbiter_pkg::*;
#(
  parameter int NREQ = RB_NREQ,
  parameter int AW   = RB_AW,
  parameter int W    = RB_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*W-1:0]  req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             grant_vld,
  output logic [2:0]       grant_id,
  output logic             locked,
  input  logic [AW-1:0]    rd_addr,
  output logic [W-1:0]     rd_data
);

  localparam int DEPTH = 1 << AW;
  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;

  rb_state_e         state_reg, state_next;
  logic [RB_IDW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [RB_IDW-1:0] owner_reg, owner_next;

  logic [NREQ-1:0]   owner_mask;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   pick_gnt;
  logic [RB_IDW-1:0] pick_idx;
  logic              pick_any;
  logic [NREQ-1:0]   lock_rot;
  logic [IW-1:0]     sel;

  logic [AW-1:0]     addr_arr [NREQ];
  logic [W-1:0]      data_arr [NREQ];
  logic [W-1:0]      bank_reg [DEPTH];

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
      assign data_arr[gi] = req_data[gi*W +: W];
    end
  endgenerate

  // While locked only the owner may compete; an owner that drops valid yields no grant.
  assign owner_mask = NREQ'(1) << owner_reg;
  assign eligible   = (state_reg == RB_ST_LOCKED) ? (req_valid & owner_mask) : req_valid;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req (eligible),
    .ptr (rr_ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Reset forces the grant outputs low immediately, not just at the next edge.
  assign req_ready = reset ? '0 : pick_gnt;
  assign grant_vld = !reset && pick_any;
  assign grant_id  = reset ? 3'd0 : pick_idx;
  assign locked    = (state_reg == RB_ST_LOCKED);

  assign sel     = pick_idx[IW-1:0];
  assign wr_en   = grant_vld;
  assign wr_addr = addr_arr[sel];
  assign wr_data = data_arr[sel];

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    owner_next  = owner_reg;
    lock_rot    = req_lock >> pick_idx;
    if (grant_vld) begin
      rr_ptr_next = rb_next_ptr(pick_idx, NREQ);
      if (lock_rot[0]) begin
        state_next = RB_ST_LOCKED;
        owner_next = pick_idx;
      end else begin
        state_next = RB_ST_IDLE;
      end
    end else if (state_reg == RB_ST_LOCKED) begin
      state_next = RB_ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= RB_ST_IDLE;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      owner_reg  <= owner_next;
    end
  end

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bank
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          bank_reg[gi] <= '0;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          bank_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Read sees the pre-write contents during a grant cycle.
  assign rd_data = bank_reg[rd_addr];

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Randomized bench for regbank_write_arbiter with an in-bench behavioural model
// checked every cycle, plus directed scenarios pinned with literal expectations.
module tb_regbank_write_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_lock = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*W-1:0]  req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              grant_vld;
  logic [2:0]        grant_id;
  logic              locked;
  logic [AW-1:0]     rd_addr = '0;
  logic [W-1:0]      rd_data;

  regbank_write_arbiter #(.NREQ(NREQ), .AW(AW), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant_vld (grant_vld),
    .grant_id  (grant_id),
    .locked    (locked),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Behavioural model: bank contents, lock holder, round-robin start point.
  logic [W-1:0] bank_m [1<<AW];
  bit           lk_m  = 1'b0;
  int           own_m = 0;
  int           ptr_m = 0;

  initial for (int i = 0; i < (1<<AW); i++) bank_m[i] = '0;

  always begin : compare
    int g;
    logic [AW-1:0] g_addr;
    logic [W-1:0]  g_data;
    bit            g_lock;
    @(negedge clk);
    g = -1;
    g_addr = '0;
    g_data = '0;
    g_lock = 1'b0;
    if (reset) begin
      for (int i = 0; i < (1<<AW); i++) bank_m[i] = '0;
      lk_m = 1'b0; own_m = 0; ptr_m = 0;
    end else if (lk_m) begin
      if (req_valid[own_m]) g = own_m;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
      end
    end
    chk("ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("grant_vld", 32'(grant_vld), (g >= 0) ? 32'd1 : 32'd0);
    chk("grant_id", 32'(grant_id), (g >= 0) ? 32'(g) : 32'd0);
    chk("locked", 32'(locked), (!reset && lk_m) ? 32'd1 : 32'd0);
    chk("rd_data", rd_data, reset ? 32'd0 : bank_m[rd_addr]);
    if (g >= 0) begin
      g_addr = req_addr[g*AW +: AW];
      g_data = req_data[g*W +: W];
      g_lock = req_lock[g];
    end
    @(posedge clk);
    if (!reset) begin
      if (g >= 0) begin
        bank_m[g_addr] = g_data;
        ptr_m = (g + 1) % NREQ;
        lk_m  = g_lock;
        if (g_lock) own_m = g;
      end else if (lk_m) begin
        lk_m = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*W +: W]   = d;
  endtask

  initial begin
    logic [NREQ-1:0] rdy_s;
    tick(); tick();
    reset = 1'b0;

    // 1: single write, read back next cycle
    req_valid = 4'b0001; set_req(0, 3'd5, 32'hDEADBEEF);
    @(negedge clk); chk("t1_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0; rd_addr = 3'd5;
    @(negedge clk); chk("t1_rd", rd_data, 32'hDEADBEEF);
    tick();

    // bring rr_ptr back to 0
    req_valid = 4'b1000; set_req(3, 3'd6, 32'h66);
    @(negedge clk); chk("prep_gid", 32'(grant_id), 32'd3);
    tick();

    // 2: all valid, rotating grants
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 32'(100 + i));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("t2_gid", 32'(grant_id), 32'(k));
      tick();
    end
    req_valid = '0; rd_addr = 3'd2;
    @(negedge clk); chk("t2_rd", rd_data, 32'd102);
    tick();

    // move rr_ptr to 1 so requester 1 wins the first lock beat
    req_valid = 4'b0001;
    @(negedge clk); chk("prep3_gid", 32'(grant_id), 32'd0);
    tick();

    // 3: locked burst by requester 1 with 0 and 2 contending
    req_valid = 4'b0111; req_lock = 4'b0010;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) req_lock = 4'b0000;
      set_req(1, 3'(4 + b), 32'(200 + b));
      @(negedge clk);
      chk("t3_gid", 32'(grant_id), 32'd1);
      chk("t3_locked", 32'(locked), (b > 0) ? 32'd1 : 32'd0);
      tick();
    end
    req_valid = 4'b0101;
    @(negedge clk); chk("t3_next_gid", 32'(grant_id), 32'd2); chk("t3_unlocked", 32'(locked), 32'd0);
    tick();

    // 4: owner 2 abandons the lock while requester 3 waits
    req_valid = 4'b0100; req_lock = 4'b0100;
    @(negedge clk); chk("t4_gid", 32'(grant_id), 32'd2);
    tick();
    req_valid = 4'b1000; req_lock = '0;
    @(negedge clk); chk("t4_novld", 32'(grant_vld), 32'd0); chk("t4_locked", 32'(locked), 32'd1);
    tick();
    @(negedge clk); chk("t4_gid3", 32'(grant_id), 32'd3); chk("t4_idle", 32'(locked), 32'd0);
    tick();

    // 6: wrap from rr_ptr 3 to 0
    req_valid = 4'b0100;
    @(negedge clk); chk("t6_prep", 32'(grant_id), 32'd2);
    tick();
    req_valid = 4'b1001;
    @(negedge clk); chk("t6_gid3", 32'(grant_id), 32'd3);
    tick();
    @(negedge clk); chk("t6_gid0", 32'(grant_id), 32'd0);
    tick();

    // 5: reset in the middle of a lock with a pending write to reg 7
    req_valid = 4'b0001; req_lock = 4'b0001; set_req(0, 3'd1, 32'h55);
    @(negedge clk); chk("t5_gid", 32'(grant_id), 32'd0);
    tick();
    set_req(0, 3'd7, 32'h1234); rd_addr = 3'd7;
    #1 reset = 1'b1;
    #1;
    chk("t5_ready", 32'(req_ready), 32'd0);
    chk("t5_vld", 32'(grant_vld), 32'd0);
    chk("t5_locked", 32'(locked), 32'd0);
    chk("t5_rd", rd_data, 32'd0);
    @(negedge clk);
    tick();
    reset = 1'b0; req_valid = '0; req_lock = '0;
    @(negedge clk); chk("t5_idle", 32'(locked), 32'd0); chk("t5_bank7", rd_data, 32'd0);
    tick();

    // randomized traffic: requesters hold their beat until it is accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rdy_s = req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || rdy_s[i]) begin
          req_valid[i] = ($urandom % 3) != 0;
          req_lock[i]  = ($urandom % 3) == 0;
          set_req(i, 3'($urandom), $urandom);
        end
      end
      rd_addr = 3'($urandom);
    end
    req_valid = '0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
